mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port CHIP-8 memory between three requesters: CPU instruction fetch, CPU data (load/store), and the display sprite reader.
- Sits between the CPU/display blocks and the memory block; drives its read/read_addr/write/write_addr/write_data and consumes read_data/read_ack.
- Round-robin arbitration with one transaction in flight. Fetch port returns a 16-bit big-endian opcode assembled from two sequential byte reads.

Parameters:
ADDR_W, 12, address width (4 KiB space)
RESERVED_END, 12'h1FF, top address of interpreter/font region (used only under optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; hold with if_addr until if_ack
if_addr  in  ADDR_W  opcode address
if_ack  out  1  one-cycle pulse, if_data valid
if_data  out  16  {mem[if_addr], mem[if_addr+1]}
dp_req  in  1  data-port request; hold with dp_we/dp_addr/dp_wdata until dp_ack
dp_we  in  1  1=write, 0=read
dp_addr  in  ADDR_W  data address
dp_wdata  in  8  write byte
dp_ack  out  1  one-cycle completion pulse
dp_rdata  out  8  read byte, valid with dp_ack
gp_req  in  1  sprite read request; hold with gp_addr until gp_ack
gp_addr  in  ADDR_W  sprite byte address
gp_ack  out  1  one-cycle pulse
gp_rdata  out  8  sprite byte, valid with gp_ack
mem_read  out  1  memory read strobe
mem_read_addr  out  ADDR_W
mem_read_data  in  8
mem_read_ack  in  1  memory read completion (one cycle after mem_read)
mem_write  out  1  memory write strobe
mem_write_addr  out  ADDR_W
mem_write_data  out  8

Behaviour:
- Interface fixed: single clock clk; reset rst_n asynchronous, active-low.
- Reset: all outputs 0, state IDLE, rr pointer = fetch; any in-flight transaction abandoned, no ack issued.
- All outputs registered. mem_read/mem_write are single-cycle pulses.
- States: IDLE, RD_WAIT (byte read, dp or gp), FETCH_HI (waiting first fetch byte), FETCH_LO (waiting second), WR_DONE.
- IDLE: sample reqs; pick first asserted in rr order starting at pointer (order fetch->dp->gp->fetch). Pointer := granted index + 1 mod 3. No req: stay IDLE.
- Grant dp write: mem_write=1 with addr/data -> WR_DONE; next edge dp_ack=1 -> IDLE. Ack visible 1 cycle after grant edge.
- Grant dp/gp read: mem_read=1 -> RD_WAIT; on mem_read_ack, capture mem_read_data into dp_rdata/gp_rdata, pulse ack -> IDLE. Ack visible 2 cycles after grant edge.
- Grant fetch: read if_addr -> FETCH_HI; on ack latch high byte, issue read at (if_addr+1) mod 2^ADDR_W -> FETCH_LO; on ack assemble if_data, pulse if_ack -> IDLE. Ack 4 cycles after grant edge. 0xFFF wraps to 0x000.
- rdata outputs hold last value until next ack of that port.
- req still high while its ack is high is treated as a new request at next IDLE sample (back-to-back allowed).
- mem_read_ack outside RD_WAIT/FETCH_* ignored.
- Simultaneous reqs never both issue; losers wait, bounded by 2 transactions (starvation-free).

Optional Feature:
- Macro MEM_ARBITER_WRITE_GUARD_EN.
- Defined: dp writes with dp_addr <= RESERVED_END issue no mem_write; dp_ack still pulses; extra output wr_fault (1 bit) pulses with that dp_ack; reset 0.
- Undefined: all writes pass; wr_fault port absent.

Decomposition:
- Package chip8_mem_pkg: ADDR_W, DATA_W=8, RESERVED_END, port index enum (PORT_IF, PORT_DP, PORT_GP), arbiter state enum.
- One sub-module natural: mem_rr_pick (combinational 3-way round-robin picker: req[2:0], ptr -> grant one-hot, valid).

Test Plan:
- Reset mid-fetch (rst_n low during FETCH_LO) -> no if_ack, all outputs 0, next grant starts from fetch.
- Fetch 0x200 with mem[0x200]=0x12, mem[0x201]=0x34 -> if_ack 4 cycles after grant, if_data=0x1234; fetch 0xFFF with mem[0xFFF]=0xAB, mem[0x000]=0xCD -> 0xABCD.
- dp write 0x300<-0x5A then dp read 0x300 -> mem_write once, dp_ack after 1 cycle; read dp_rdata=0x5A after 2.
- All three reqs held from reset -> grant order fetch, dp, gp, fetch; each ack exactly once per grant, never two mem strobes same cycle.
- gp held continuously, dp asserted -> dp acked within 2 transactions.
- With MEM_ARBITER_WRITE_GUARD_EN, dp write 0x1B0 <- 0xFF -> no mem_write, dp_ack + wr_fault pulse, mem[0x1B0] unchanged; write 0x200 passes, wr_fault=0.

Source files
------------

// File: rtl/chip8_mem_pkg.sv
// chip8_mem_pkg: shared widths, reserved-region bound, requester and arbiter-state enums, round-robin successor helper
package chip8_mem_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] RESERVED_END = 12'h1FF;
  typedef enum logic [1:0] {PORT_IF, PORT_DP, PORT_GP} port_e;
  typedef enum logic [2:0] {IDLE, RD_WAIT, FETCH_HI, FETCH_LO, WR_DONE} state_e;
  function automatic port_e next_port(input port_e p);
    return p == PORT_GP ? PORT_IF : p == PORT_IF ? PORT_DP : PORT_GP;
  endfunction
endpackage

// File: rtl/mem_rr_pick.sv
// mem_rr_pick: combinational 3-way round-robin picker; req_i {gp,dp,if}, ptr_i first port to consider, grant_o one-hot, valid_o any request
module mem_rr_pick
  import chip8_mem_pkg::*;
(
  input  logic [2:0] req_i,
  input  port_e      ptr_i,
  output logic [2:0] grant_o,
  output logic       valid_o
);
  logic [2:0] rot;
  logic [2:0] pick;
  always_comb begin
    rot = ptr_i == PORT_IF ? req_i : ptr_i == PORT_DP ? {req_i[0], req_i[2:1]} : {req_i[1:0], req_i[2]};
    pick = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
    grant_o = ptr_i == PORT_IF ? pick : ptr_i == PORT_DP ? {pick[1:0], pick[2]} : {pick[0], pick[2:1]};
    valid_o = |req_i;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of single-port CHIP-8 memory between fetch (if_*, 16-bit big-endian opcode), data (dp_*, byte rd/wr) and sprite (gp_*, byte rd) ports; drives mem_* strobes, all outputs registered; MEM_ARBITER_WRITE_GUARD_EN blocks dp writes at or below RESERVED_END and adds wr_fault_o
module mem_arbiter #(
  parameter int ADDR_W = chip8_mem_pkg::ADDR_W
`ifdef MEM_ARBITER_WRITE_GUARD_EN
  , parameter logic [ADDR_W-1:0] RESERVED_END = chip8_mem_pkg::RESERVED_END
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [15:0]       if_data_o,
  input  logic              dp_req_i,
  input  logic              dp_we_i,
  input  logic [ADDR_W-1:0] dp_addr_i,
  input  logic [7:0]        dp_wdata_i,
  output logic              dp_ack_o,
  output logic [7:0]        dp_rdata_o,
  input  logic              gp_req_i,
  input  logic [ADDR_W-1:0] gp_addr_i,
  output logic              gp_ack_o,
  output logic [7:0]        gp_rdata_o,
  output logic              mem_read_o,
  output logic [ADDR_W-1:0] mem_read_addr_o,
  input  logic [7:0]        mem_read_data_i,
  input  logic              mem_read_ack_i,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_write_addr_o,
  output logic [7:0]        mem_write_data_o
`ifdef MEM_ARBITER_WRITE_GUARD_EN
  , output logic            wr_fault_o
`endif
);
  import chip8_mem_pkg::*;
  state_e state_q, state_d;
  port_e ptr_q, ptr_d, own_q, own_d;
  logic [2:0] grant;
  logic valid, blocked;
  logic [DATA_W-1:0] hi_q, hi_d, dp_rdata_q, dp_rdata_d, gp_rdata_q, gp_rdata_d, wdata_q, wdata_d;
  logic [15:0] if_data_q, if_data_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
  logic if_ack_q, if_ack_d, dp_ack_q, dp_ack_d, gp_ack_q, gp_ack_d, rd_q, rd_d, wr_q, wr_d;
`ifdef MEM_ARBITER_WRITE_GUARD_EN
  logic fault_q, fault_d;
  assign blocked = dp_addr_i <= RESERVED_END;
  assign wr_fault_o = fault_q;
`else
  assign blocked = 1'b0;
`endif
  mem_rr_pick u_pick (
    .req_i  ({gp_req_i, dp_req_i, if_req_i}),
    .ptr_i  (ptr_q),
    .grant_o(grant),
    .valid_o(valid)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    own_d = own_q;
    hi_d = hi_q;
    if_data_d = if_data_q;
    dp_rdata_d = dp_rdata_q;
    gp_rdata_d = gp_rdata_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if_ack_d = 1'b0;
    dp_ack_d = 1'b0;
    gp_ack_d = 1'b0;
    rd_d = 1'b0;
    wr_d = 1'b0;
`ifdef MEM_ARBITER_WRITE_GUARD_EN
    fault_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (valid) begin
        ptr_d = next_port(grant[0] ? PORT_IF : grant[1] ? PORT_DP : PORT_GP);
        if (grant[0]) begin
          rd_d = 1'b1;
          raddr_d = if_addr_i;
          state_d = FETCH_HI;
        end else if (grant[1] && dp_we_i) begin
          wr_d = !blocked;
          waddr_d = dp_addr_i;
          wdata_d = dp_wdata_i;
          state_d = WR_DONE;
        end else begin
          rd_d = 1'b1;
          raddr_d = grant[1] ? dp_addr_i : gp_addr_i;
          own_d = grant[1] ? PORT_DP : PORT_GP;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: if (mem_read_ack_i) begin
        dp_ack_d = own_q == PORT_DP;
        gp_ack_d = own_q == PORT_GP;
        dp_rdata_d = own_q == PORT_DP ? mem_read_data_i : dp_rdata_q;
        gp_rdata_d = own_q == PORT_GP ? mem_read_data_i : gp_rdata_q;
        state_d = IDLE;
      end
      FETCH_HI: if (mem_read_ack_i) begin
        hi_d = mem_read_data_i;
        rd_d = 1'b1;
        raddr_d = if_addr_i + ADDR_W'(1);
        state_d = FETCH_LO;
      end
      FETCH_LO: if (mem_read_ack_i) begin
        if_data_d = {hi_q, mem_read_data_i};
        if_ack_d = 1'b1;
        state_d = IDLE;
      end
      WR_DONE: begin
        dp_ack_d = 1'b1;
`ifdef MEM_ARBITER_WRITE_GUARD_EN
        fault_d = blocked;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= PORT_IF;
      own_q <= PORT_IF;
      hi_q <= '0;
      if_data_q <= '0;
      dp_rdata_q <= '0;
      gp_rdata_q <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      if_ack_q <= 1'b0;
      dp_ack_q <= 1'b0;
      gp_ack_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
`ifdef MEM_ARBITER_WRITE_GUARD_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      hi_q <= hi_d;
      if_data_q <= if_data_d;
      dp_rdata_q <= dp_rdata_d;
      gp_rdata_q <= gp_rdata_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      if_ack_q <= if_ack_d;
      dp_ack_q <= dp_ack_d;
      gp_ack_q <= gp_ack_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
`ifdef MEM_ARBITER_WRITE_GUARD_EN
      fault_q <= fault_d;
`endif
    end
  end
  assign if_ack_o = if_ack_q;
  assign if_data_o = if_data_q;
  assign dp_ack_o = dp_ack_q;
  assign dp_rdata_o = dp_rdata_q;
  assign gp_ack_o = gp_ack_q;
  assign gp_rdata_o = gp_rdata_q;
  assign mem_read_o = rd_q;
  assign mem_read_addr_o = raddr_q;
  assign mem_write_o = wr_q;
  assign mem_write_addr_o = waddr_q;
  assign mem_write_data_o = wdata_q;
endmodule
